// File: rtl/lift_call_dispatcher.sv
// rtl/lift_call_dispatcher.sv - SCAN call dispatcher driving the lift floor code
module lift_call_dispatcher #(
   parameter int DWELL_CYCLES   = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] call_btn,
   input  logic [3:0] floor_onehot,
   output logic [1:0] req_floor,
   output logic [3:0] pending,
   output logic       door_open,
   output logic       dir_up,
   output logic       busy,
   output logic       fault
);
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_TRAVEL = 2'd1;
   localparam logic [1:0] ST_DOOR   = 2'd2;
   localparam logic [1:0] ST_FAULT  = 2'd3;
   localparam int DW = $clog2(DWELL_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]    state;
   logic [3:0]    btn_q;
   logic [1:0]    target;
   logic [DW-1:0] dwell_cnt;
   logic [TW-1:0] tmo_cnt;

   logic [3:0]    rise;
   logic          cur_valid;
   logic [1:0]    cur;
   logic          up_found;
   logic          dn_found;
   logic [1:0]    up_floor;
   logic [1:0]    dn_floor;
   logic          go_up;
   logic [1:0]    next_tgt;
   logic          arrived;
   logic          idle_hit;
   logic          restart;
   logic [3:0]    clr;
   logic [3:0]    latch;
   logic [DW-1:0] dwell_done;

   assign busy = (state == ST_TRAVEL) || (state == ST_DOOR);
   assign rise = call_btn & ~btn_q;

   // Decode the lift position; only a single set indicator is trusted
   always_comb begin
      cur_valid = $onehot(floor_onehot);
      case (floor_onehot)
         4'b0010: cur = 2'd1;
         4'b0100: cur = 2'd2;
         4'b1000: cur = 2'd3;
         default: cur = 2'd0;
      endcase
   end

   // Nearest pending floor above and below the current floor
   always_comb begin
      up_found = 1'b0;
      up_floor = 2'd0;
      dn_found = 1'b0;
      dn_floor = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (i > int'(cur) && pending[i]) begin
            up_found = 1'b1;
            up_floor = 2'(i);
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (i < int'(cur) && pending[i]) begin
            dn_found = 1'b1;
            dn_floor = 2'(i);
         end
      end
   end

   // SCAN choice, call clearing, and door-hold restart decisions
   always_comb begin
      go_up      = dir_up ? up_found : ~dn_found;
      next_tgt   = go_up ? up_floor : dn_floor;
      arrived    = (state == ST_TRAVEL) && cur_valid && (cur == target);
      idle_hit   = (state == ST_IDLE) && cur_valid && pending[cur];
      restart    = (state == ST_DOOR) && cur_valid && rise[cur];
      clr        = 4'b0000;
      if (idle_hit) clr = 4'b0001 << cur;
      if (arrived)  clr = 4'b0001 << target;
      latch      = rise;
      if (restart) latch[cur] = 1'b0;
      dwell_done = restart ? DW'(1) : dwell_cnt + 1'b1;
   end

   // Main controller state and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         btn_q     <= 4'b0000;
         pending   <= 4'b0000;
         target    <= 2'd0;
         req_floor <= 2'd0;
         door_open <= 1'b0;
         dir_up    <= 1'b1;
         fault     <= 1'b0;
         dwell_cnt <= '0;
         tmo_cnt   <= '0;
      end else begin
         btn_q   <= call_btn;
         pending <= (pending | latch) & ~clr;
         case (state)
            ST_IDLE: begin
               if (cur_valid) begin
                  req_floor <= cur;
                  if (pending[cur]) begin
                     state     <= ST_DOOR;
                     door_open <= 1'b1;
                     dwell_cnt <= '0;
                  end else if (pending != 4'b0000) begin
                     state     <= ST_TRAVEL;
                     dir_up    <= go_up;
                     target    <= next_tgt;
                     req_floor <= next_tgt;
                     tmo_cnt   <= '0;
                  end
               end
            end
            ST_TRAVEL: begin
               if (arrived) begin
                  state     <= ST_DOOR;
                  door_open <= 1'b1;
                  dwell_cnt <= '0;
               end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  state     <= ST_FAULT;
                  fault     <= 1'b1;
                  req_floor <= 2'd0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_DOOR: begin
               if (dwell_done >= DW'(DWELL_CYCLES)) begin
                  state     <= ST_IDLE;
                  door_open <= 1'b0;
                  dwell_cnt <= '0;
               end else begin
                  dwell_cnt <= dwell_done;
               end
            end
            default: begin
               fault     <= 1'b1;
               req_floor <= 2'd0;
               door_open <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_lift_call_dispatcher.sv
// tb/tb_lift_call_dispatcher.sv - bench for lift_call_dispatcher
module tb_lift_call_dispatcher;
   localparam int DWELL   = 8;
   localparam int TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] call_btn;
   logic [3:0] floor_onehot;
   logic [1:0] req_floor;
   logic [3:0] pending;
   logic       door_open;
   logic       dir_up;
   logic       busy;
   logic       fault;

   int         n_tests = 0;
   int         n_fail  = 0;
   bit         lift_auto = 1'b0;
   logic [1:0] lift_pend = 2'd0;

   typedef struct {
      logic [3:0] btn;
      logic [3:0] fl;
      logic [1:0] req;
      logic [3:0] pend;
      logic       door;
      logic       bsy;
   } vec_t;
   vec_t tbl[13];

   // reference model state
   int         m_mode;
   logic [1:0] m_req;
   logic [1:0] m_tgt;
   logic [3:0] m_pend;
   logic [3:0] m_prev;
   logic       m_door;
   logic       m_dir;
   logic       m_fault;
   int         m_trav;
   int         m_left;

   lift_call_dispatcher #(.DWELL_CYCLES(DWELL), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .call_btn(call_btn), .floor_onehot(floor_onehot),
      .req_floor(req_floor), .pending(pending), .door_open(door_open),
      .dir_up(dir_up), .busy(busy), .fault(fault)
   );

   // free-running clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // advance to the next falling edge; the lift takes the floor code one edge late
   task automatic clk_step();
      @(negedge clk);
      if (lift_auto) begin
         floor_onehot = 4'b0001 << lift_pend;
         lift_pend    = req_floor;
      end
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      call_btn     = 4'b0000;
      floor_onehot = 4'b0001;
      lift_pend    = 2'd0;
      clk_step();
      clk_step();
      rst = 1'b0;
   endtask

   task automatic wait_busy_low(input string name);
      for (int k = 0; k < 40 && busy; k++) clk_step();
      chk(name, busy, 1'b0);
   endtask

   task automatic model_reset();
      m_mode = 0; m_req = 2'd0; m_tgt = 2'd0; m_pend = 4'b0; m_prev = 4'b0;
      m_door = 1'b0; m_dir = 1'b1; m_fault = 1'b0; m_trav = 0; m_left = 0;
   endtask

   // one clock edge of the lift dispatcher, from the behavioural rules
   task automatic model_step(input logic [3:0] b, input logic [3:0] f);
      logic [3:0] rise;
      logic [3:0] add;
      logic [3:0] clr;
      int         cur;
      int         found;
      int         fl;
      bit         ok;
      rise   = b & ~m_prev;
      m_prev = b;
      add    = rise;
      clr    = 4'b0;
      ok     = ($countones(f) == 1);
      cur    = 0;
      for (int i = 0; i < 4; i++) if (f[i]) cur = i;
      case (m_mode)
         0: if (ok) begin
            m_req = 2'(cur);
            if (m_pend[cur]) begin
               clr[cur] = 1'b1; m_mode = 2; m_door = 1'b1; m_left = DWELL;
            end else if (m_pend != 4'b0) begin
               found = -1;
               for (int pass = 0; pass < 2 && found < 0; pass++) begin
                  for (int d = 1; d < 4 && found < 0; d++) begin
                     fl = m_dir ? cur + d : cur - d;
                     if (fl >= 0 && fl < 4 && m_pend[fl]) found = fl;
                  end
                  if (found < 0) m_dir = ~m_dir;
               end
               m_tgt = 2'(found); m_req = 2'(found); m_mode = 1; m_trav = 0;
            end
         end
         1: if (ok && cur == int'(m_tgt)) begin
            clr[m_tgt] = 1'b1; m_mode = 2; m_door = 1'b1; m_left = DWELL;
         end else begin
            m_trav++;
            if (m_trav >= TIMEOUT) begin m_mode = 3; m_fault = 1'b1; m_req = 2'd0; end
         end
         2: begin
            if (ok && rise[cur]) begin add[cur] = 1'b0; m_left = DWELL - 1; end
            else m_left--;
            if (m_left <= 0) begin m_mode = 0; m_door = 1'b0; end
         end
         default: ;
      endcase
      m_pend = (m_pend | add) & ~clr;
   endtask

   initial begin
      int doors;
      bit prev_door;
      int high;
      logic m_busy;

      tbl[0]  = '{4'b0100, 4'b0001, 2'd0, 4'b0100, 1'b0, 1'b0};
      tbl[1]  = '{4'b0000, 4'b0001, 2'd2, 4'b0100, 1'b0, 1'b1};
      tbl[2]  = '{4'b0000, 4'b0001, 2'd2, 4'b0100, 1'b0, 1'b1};
      tbl[3]  = '{4'b0000, 4'b0100, 2'd2, 4'b0000, 1'b1, 1'b1};
      for (int i = 4; i <= 10; i++) tbl[i] = '{4'b0000, 4'b0100, 2'd2, 4'b0000, 1'b1, 1'b1};
      tbl[11] = '{4'b0000, 4'b0100, 2'd2, 4'b0000, 1'b0, 1'b0};
      tbl[12] = '{4'b0000, 4'b0100, 2'd2, 4'b0000, 1'b0, 1'b0};

      // reset state
      rst = 1'b1; call_btn = 4'b0; floor_onehot = 4'b0001;
      clk_step();
      chk("rst_req", req_floor, 2'd0);
      chk("rst_pending", pending, 4'b0);
      chk("rst_door", door_open, 1'b0);
      chk("rst_dir", dir_up, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_fault", fault, 1'b0);
      do_reset();

      // single call from floor 0 to floor 2 with full dwell
      for (int i = 0; i < 13; i++) begin
         call_btn     = tbl[i].btn;
         floor_onehot = tbl[i].fl;
         clk_step();
         chk($sformatf("vec%0d_req", i), req_floor, tbl[i].req);
         chk($sformatf("vec%0d_pending", i), pending, tbl[i].pend);
         chk($sformatf("vec%0d_door", i), door_open, tbl[i].door);
         chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
      end

      // held button is served once
      do_reset();
      lift_auto = 1'b1;
      call_btn = 4'b0010;
      doors = 0; prev_door = 1'b0;
      repeat (20) begin
         clk_step();
         if (door_open && !prev_door) doors++;
         prev_door = door_open;
      end
      chk("hold_door_visits", doors, 1);
      chk("hold_pending", pending, 4'b0000);
      call_btn = 4'b0000;
      repeat (12) clk_step();
      chk("hold_after_pending", pending, 4'b0000);
      chk("hold_after_busy", busy, 1'b0);

      // SCAN: at floor 1 going up with calls at 0 and 3
      call_btn = 4'b1001;
      clk_step();
      call_btn = 4'b0000;
      clk_step();
      chk("scan_first_req", req_floor, 2'd3);
      chk("scan_first_dir", dir_up, 1'b1);
      wait_busy_low("scan_first_done");
      clk_step();
      chk("scan_second_req", req_floor, 2'd0);
      chk("scan_second_dir", dir_up, 1'b0);
      chk("scan_second_busy", busy, 1'b1);
      wait_busy_low("scan_second_done");
      chk("scan_pending", pending, 4'b0000);
      chk("scan_final_req", req_floor, 2'd0);

      // door hold restarted by the floor's own button at dwell count 5
      call_btn = 4'b0100;
      clk_step();
      call_btn = 4'b0000;
      for (int k = 0; k < 20 && !door_open; k++) clk_step();
      chk("dwell_door_reached", door_open, 1'b1);
      high = 1;
      repeat (5) begin
         clk_step();
         if (door_open) high++;
      end
      call_btn = 4'b0100;
      clk_step();
      if (door_open) high++;
      call_btn = 4'b0000;
      for (int k = 0; k < 30; k++) begin
         clk_step();
         if (!door_open) break;
         high++;
      end
      chk("dwell_restart_len", high, 13);
      chk("dwell_restart_pending", pending, 4'b0000);

      // new press on the arrival cycle is cleared with the call
      call_btn = 4'b1000;
      clk_step();
      call_btn = 4'b0000;
      clk_step();
      chk("arrive_req", req_floor, 2'd3);
      clk_step();
      call_btn = 4'b1000;
      clk_step();
      chk("arrive_door", door_open, 1'b1);
      chk("arrive_pending", pending, 4'b0000);
      call_btn = 4'b0000;
      wait_busy_low("arrive_done");

      // lift never reaches floor 3 -> fault after the timeout
      lift_auto = 1'b0;
      floor_onehot = 4'b0001;
      call_btn = 4'b1000;
      clk_step();
      call_btn = 4'b0000;
      clk_step();
      chk("tmo_busy", busy, 1'b1);
      chk("tmo_req", req_floor, 2'd3);
      repeat (15) clk_step();
      chk("tmo_not_yet", fault, 1'b0);
      clk_step();
      chk("tmo_fault", fault, 1'b1);
      chk("tmo_req_ground", req_floor, 2'd0);
      chk("tmo_busy_low", busy, 1'b0);
      call_btn = 4'b0010;
      clk_step();
      call_btn = 4'b0000;
      repeat (20) clk_step();
      chk("fault_sticky", fault, 1'b1);
      chk("fault_latch", pending, 4'b1010);
      chk("fault_door", door_open, 1'b0);
      rst = 1'b1;
      #1;
      chk("fault_rst_fault", fault, 1'b0);
      chk("fault_rst_pending", pending, 4'b0000);
      chk("fault_rst_dir", dir_up, 1'b1);

      // asynchronous reset in the middle of a trip
      do_reset();
      lift_auto = 1'b1;
      call_btn = 4'b0100;
      clk_step();
      call_btn = 4'b0000;
      clk_step();
      clk_step();
      chk("mid_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      chk("mid_rst_req", req_floor, 2'd0);
      chk("mid_rst_pending", pending, 4'b0000);
      chk("mid_rst_busy", busy, 1'b0);

      // randomized traffic against the reference model
      do_reset();
      model_reset();
      model_step(call_btn, floor_onehot);
      for (int cyc = 0; cyc < 800; cyc++) begin
         clk_step();
         m_busy = (m_mode == 1) || (m_mode == 2);
         chk($sformatf("rand_cyc%0d {req,pend,door,dir,busy,fault}", cyc),
             {req_floor, pending, door_open, dir_up, busy, fault},
             {m_req, m_pend, m_door, m_dir, m_busy, m_fault});
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 9) == 0) call_btn[b] = ~call_btn[b];
         if ($urandom_range(0, 29) == 0) floor_onehot = 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 149) == 0);
         if (rst) model_reset();
         else     model_step(call_btn, floor_onehot);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
